// File: rtl/tap_shift_register_if.sv
// Handshake/data bundle for tap_shift_register: the source drives en/clr/d, the chain returns taps and window status.
interface tap_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                        en;
  logic                        clr;
  logic [WIDTH-1:0]            d;
  logic [DEPTH-1:0][WIDTH-1:0] taps;
  logic [WIDTH-1:0]            q;
  logic [CW-1:0]               fill_cnt;
  logic                        full;
  logic                        win_valid;

  modport master (output en, clr, d, input taps, q, fill_cnt, full, win_valid);
  modport slave  (input en, clr, d, output taps, q, fill_cnt, full, win_valid);
endinterface

// File: rtl/tap_shift_register.sv
// WIDTH-bit, DEPTH-stage enabled shift chain exposing every stage as a tap,
// with a saturating fill count and a per-shift complete-window strobe.
module tap_shift_register #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tap_shift_register_if.slave  bus
);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;
  logic [CW-1:0]               r_fill_cnt;
  logic                        r_win_valid;
  logic [CW-1:0]               w_fill_nxt;

  // Saturate at DEPTH so a long stream never wraps back to "not full".
  assign w_fill_nxt = (r_fill_cnt == FULL_CNT) ? r_fill_cnt : r_fill_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      r_stage     <= '0;
      r_fill_cnt  <= '0;
      r_win_valid <= 1'b0;
    end else if (bus.en) begin
      r_stage[0] <= bus.d;
      for (int i = 1; i < DEPTH; i++)
        r_stage[i] <= r_stage[i-1];
      r_fill_cnt  <= w_fill_nxt;
      r_win_valid <= (w_fill_nxt == FULL_CNT);
    end else begin
      r_win_valid <= 1'b0;
    end
  end

  assign bus.taps      = r_stage;
  assign bus.q         = r_stage[DEPTH-1];
  assign bus.fill_cnt  = r_fill_cnt;
  assign bus.full      = (r_fill_cnt == FULL_CNT);
  assign bus.win_valid = r_win_valid;
endmodule

// File: tb/tb_tap_shift_register.sv
// Directed bench for tap_shift_register: a DEPTH=3 chain and a DEPTH=1 chain on one clock.
module tb_tap_shift_register;
  logic clk = 1'b0;
  logic rst_n, rst1_n;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  tap_shift_register_if #(.WIDTH(8), .DEPTH(3)) bus3 ();
  tap_shift_register_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

  tap_shift_register #(.WIDTH(8), .DEPTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n),  .bus(bus3.slave));
  tap_shift_register #(.WIDTH(8), .DEPTH(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the 3-deep chain, take one edge, sample 1 time unit later.
  task automatic step3(input logic en, input logic clr, input logic [7:0] d);
    bus3.en = en; bus3.clr = clr; bus3.d = d;
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic en, input logic clr, input logic [7:0] d);
    bus1.en = en; bus1.clr = clr; bus1.d = d;
    @(posedge clk); #1;
  endtask

  task automatic state3(input string tag, input logic [23:0] taps, input logic [1:0] cnt,
                        input logic full, input logic wv);
    chk({tag, ".taps"}, {8'h0, bus3.taps}, {8'h0, taps});
    chk({tag, ".q"},    {24'h0, bus3.q},   {24'h0, taps[23:16]});
    chk({tag, ".cnt"},  {30'h0, bus3.fill_cnt}, {30'h0, cnt});
    chk({tag, ".full"}, {31'h0, bus3.full}, {31'h0, full});
    chk({tag, ".wv"},   {31'h0, bus3.win_valid}, {31'h0, wv});
  endtask

  task automatic state1(input string tag, input logic [7:0] q, input logic cnt,
                        input logic full, input logic wv);
    chk({tag, ".taps"}, {24'h0, bus1.taps}, {24'h0, q});
    chk({tag, ".q"},    {24'h0, bus1.q},    {24'h0, q});
    chk({tag, ".cnt"},  {31'h0, bus1.fill_cnt}, {31'h0, cnt});
    chk({tag, ".full"}, {31'h0, bus1.full}, {31'h0, full});
    chk({tag, ".wv"},   {31'h0, bus1.win_valid}, {31'h0, wv});
  endtask

  initial begin
    // Reset both chains with en high and d all ones.
    rst_n = 1'b0; rst1_n = 1'b0;
    bus1.en = 1'b1; bus1.clr = 1'b0; bus1.d = 8'hFF;
    step3(1'b1, 1'b0, 8'hFF);
    step3(1'b1, 1'b0, 8'hFF);
    state3("rst", 24'h000000, 2'd0, 1'b0, 1'b0);
    state1("rst1", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; rst1_n = 1'b1;
    bus1.en = 1'b0;

    // Fill
    step3(1'b1, 1'b0, 8'h11); state3("fill1", 24'h000011, 2'd1, 1'b0, 1'b0);
    step3(1'b1, 1'b0, 8'h22); state3("fill2", 24'h001122, 2'd2, 1'b0, 1'b0);
    step3(1'b1, 1'b0, 8'h33); state3("fill3", 24'h112233, 2'd3, 1'b1, 1'b1);

    // Hold with unknown d: nothing moves, strobe drops, full stays.
    step3(1'b0, 1'b0, 8'hxx); state3("holdx", 24'h112233, 2'd3, 1'b1, 1'b0);

    // Streaming while full
    step3(1'b1, 1'b0, 8'h44); state3("str44", 24'h223344, 2'd3, 1'b1, 1'b1);
    step3(1'b1, 1'b0, 8'h55); state3("str55", 24'h334455, 2'd3, 1'b1, 1'b1);

    // clr wins over en; 99 must not be captured.
    step3(1'b1, 1'b1, 8'h99); state3("clren", 24'h000000, 2'd0, 1'b0, 1'b0);

    // Gapped enable from empty
    step3(1'b1, 1'b0, 8'hA1); state3("gapA1", 24'h0000A1, 2'd1, 1'b0, 1'b0);
    step3(1'b0, 1'b0, 8'hEE); state3("idle1", 24'h0000A1, 2'd1, 1'b0, 1'b0);
    step3(1'b0, 1'b0, 8'hEE); state3("idle2", 24'h0000A1, 2'd1, 1'b0, 1'b0);
    step3(1'b1, 1'b0, 8'hA2); state3("gapA2", 24'h00A1A2, 2'd2, 1'b0, 1'b0);
    step3(1'b0, 1'b0, 8'hEE); state3("idle3", 24'h00A1A2, 2'd2, 1'b0, 1'b0);
    step3(1'b1, 1'b0, 8'hA3); state3("gapA3", 24'hA1A2A3, 2'd3, 1'b1, 1'b1);
    step3(1'b0, 1'b0, 8'hEE); state3("idle4", 24'hA1A2A3, 2'd3, 1'b1, 1'b0);

    // Plain clr without en, then refill needs three new shifts before any strobe.
    step3(1'b0, 1'b1, 8'hEE); state3("clr",   24'h000000, 2'd0, 1'b0, 1'b0);
    step3(1'b1, 1'b0, 8'h01); state3("re1",   24'h000001, 2'd1, 1'b0, 1'b0);
    step3(1'b1, 1'b0, 8'h02); state3("re2",   24'h000102, 2'd2, 1'b0, 1'b0);
    step3(1'b1, 1'b0, 8'h03); state3("re3",   24'h010203, 2'd3, 1'b1, 1'b1);
    bus3.en = 1'b0;

    // DEPTH=1 chain
    step1(1'b1, 1'b0, 8'h5A); state1("d1_5A", 8'h5A, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 8'h6B); state1("d1_6B", 8'h6B, 1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b0, 8'h00); state1("d1_hold", 8'h6B, 1'b1, 1'b1, 1'b0);
    rst1_n = 1'b0;
    step1(1'b1, 1'b0, 8'h77); state1("d1_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst1_n = 1'b1;
    step1(1'b1, 1'b0, 8'h12); state1("d1_12", 8'h12, 1'b1, 1'b1, 1'b1);

    // The 3-deep chain must have been untouched by all of the above.
    state3("d3_idle", 24'h010203, 2'd3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
